dp_ram_stream_reader: RTL and testbench

- Read-side master for the dual-port RAM's registered read port (address/enable in, data one clock later).
- On a start command, it fetches a contiguous burst of words from a base address and emits them as an AXI-Stream master with full valid/ready backpressure.
- Pairs with existing RAM writers, e.g. capture and scope buffers, to drain stored samples into downstream DMA or stream logic.

---
 rtl/dp_ram_stream_reader_pkg.sv | 15 +
 rtl/dp_ram_stream_reader_if.sv | 12 +
 rtl/dp_ram_stream_reader_stream_skid_fifo.sv | 72 +++++++
 rtl/dp_ram_stream_reader.sv | 141 ++++++++++++++
 tb/tb_dp_ram_stream_reader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_ram_stream_reader_pkg.sv
// Shared types and sizing for the RAM burst reader and its capture buffer.
package dp_ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int unsigned BUF_DEPTH   = 4;
  localparam int unsigned ISSUE_LIMIT = 2;
  localparam int unsigned OCC_W       = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/dp_ram_stream_reader_if.sv
// AXI-Stream style output bus of the burst reader.
interface dp_ram_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/dp_ram_stream_reader_stream_skid_fifo.sv
// Small capture FIFO whose head word and valid flag come straight from flops.
module dp_ram_stream_reader_stream_skid_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  pop_ok, push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Popped slots are zeroed so an empty buffer presents zero data.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    pop_ok  = pop && (cnt_q != '0);
    push_ok = push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
    if (pop_ok) begin
      mem_d[rd_q] = '0;
      rd_d        = ptr_inc(rd_q);
    end
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end
    cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    valid_d = (cnt_d != '0);
    head_d  = mem_d[rd_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  assign occupancy  = cnt_q;
  assign head_valid = valid_q;
  assign head_data  = head_q;

endmodule

// File: rtl/dp_ram_stream_reader.sv
// Fetches a contiguous burst from a registered-read RAM port and streams it out
// with full backpressure; reads are throttled so the capture buffer never overflows.
module dp_ram_stream_reader
  import dp_ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  input  logic [DATA_WIDTH-1:0] ram_data,
  dp_ram_stream_reader_if.master m_axis,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
  localparam int unsigned LOAD_W = OCC_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  en_q, en_d;
  logic                  en_last_q, en_last_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic [LEN_W-1:0]      left_q, left_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [OCC_W-1:0]      fifo_occ;
  logic [OCC_W-1:0]      occ_next_c;
  logic [LOAD_W-1:0]     load_c;
  logic                  pop_c;
  logic [DATA_WIDTH:0]   head_c;
  logic                  head_valid_c;

  dp_ram_stream_reader_stream_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH + 1),
    .DEPTH      (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (pend_q),
    .push_data  ({pend_last_q, ram_data}),
    .pop        (pop_c),
    .occupancy  (fifo_occ),
    .head_valid (head_valid_c),
    .head_data  (head_c)
  );

  assign pop_c = m_axis.m_tvalid && m_axis.m_tready;

  // Issue decision looks one cycle ahead because ram_en is registered.
  always_comb begin
    occ_next_c  = fifo_occ + OCC_W'(pend_q) - OCC_W'(pop_c);
    load_c      = LOAD_W'(occ_next_c) + LOAD_W'(en_q);
    state_d     = state_q;
    addr_d      = addr_q;
    en_d        = 1'b0;
    en_last_d   = 1'b0;
    pend_d      = en_q;
    pend_last_d = en_last_q;
    left_d      = left_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_FETCH;
            busy_d    = 1'b1;
            en_d      = 1'b1;
            addr_d    = base_addr;
            left_d    = length - LEN_W'(1);
            en_last_d = (length == LEN_W'(1));
          end
        end
      end
      ST_FETCH: begin
        if (left_q == '0) begin
          state_d = ST_DRAIN;
        end else if (load_c <= LOAD_W'(ISSUE_LIMIT)) begin
          en_d      = 1'b1;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          left_d    = left_q - LEN_W'(1);
          en_last_d = (left_q == LEN_W'(1));
        end
      end
      ST_DRAIN: begin
        if ((occ_next_c == '0) && !en_q) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      en_q        <= 1'b0;
      en_last_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      left_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      en_last_q   <= en_last_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      left_q      <= left_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_addr        = addr_q;
  assign ram_en          = en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign m_axis.m_tvalid = head_valid_c;
  assign m_axis.m_tdata  = head_c[DATA_WIDTH-1:0];
  assign m_axis.m_tlast  = head_c[DATA_WIDTH];

endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks them.
module tb_dp_ram_stream_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic [DW-1:0] ram_data;
  logic          busy;
  logic          done;

  dp_ram_stream_reader_if #(.DATA_WIDTH(DW)) axis ();

  dp_ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .ram_addr  (ram_addr),
    .ram_en    (ram_en),
    .ram_data  (ram_data),
    .m_axis    (axis),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            c0 = 0;
  logic [DW-1:0] ram [256];
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_log [$];
  int            first_en = -1;
  int            first_valid = -1;
  int            last_hs = -1;
  int            done_cnt = 0;
  int            max_occ = 0;
  int            stall_errs = 0;
  bit            stalled = 1'b0;
  logic [DW:0]   held = '0;
  bit            bp_mode = 1'b0;
  bit            rdy_default = 1'b1;
  logic [47:0]   pat = 48'hA5C0_0F3B_002D;
  int            bp_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM model
  always @(posedge clk) if (ram_en) ram_data <= ram[ram_addr];

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      axis.m_tready = pat[bp_idx % 48];
      bp_idx++;
    end else begin
      axis.m_tready = rdy_default;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, occupancy and event logging
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_en) begin
        addr_log.push_back(ram_addr);
        if (first_en < 0) first_en = cyc;
      end
      if (axis.m_tvalid && first_valid < 0) first_valid = cyc;
      if (int'(dut.u_fifo.occupancy) > max_occ) max_occ = int'(dut.u_fifo.occupancy);
      if (stalled && (!axis.m_tvalid || {axis.m_tlast, axis.m_tdata} != held)) stall_errs++;
      stalled = axis.m_tvalid && !axis.m_tready;
      held    = {axis.m_tlast, axis.m_tdata};
      if (axis.m_tvalid && axis.m_tready) begin
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %0d last %0d, expected no beat", axis.m_tdata, axis.m_tlast);
        end else begin
          check("beat", 64'({axis.m_tlast, axis.m_tdata}), 64'(exp_q.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    first_en    = -1;
    first_valid = -1;
    max_occ     = 0;
    stall_errs  = 0;
  endtask

  // Call just after a rising edge; start is high for that one cycle (cycle c0).
  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l, input bit expect_it);
    c0        = cyc;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    if (expect_it)
      for (int i = 0; i < int'(l); i++)
        exp_q.push_back({1'(i == int'(l) - 1), ram[(int'(b) + i) % 256]});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dc);
    dc = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) check("done_timeout", 64'(0), 64'(1));
  endtask

  function automatic logic [AW-1:0] log_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : '1;
  endfunction

  initial begin
    int dc;
    int dcnt;
    for (int i = 0; i < 256; i++) ram[i] = DW'(i + 100);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ram_en", 64'(ram_en), 0);
    check("rst_ram_addr", 64'(ram_addr), 0);
    check("rst_tvalid", 64'(axis.m_tvalid), 0);
    check("rst_tlast", 64'(axis.m_tlast), 0);
    check("rst_tdata", 64'(axis.m_tdata), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);

    // Basic burst: 105..108, fixed latencies
    @(posedge clk); #1;
    clear_logs();
    do_start(8'd5, 9'd4, 1'b1);
    wait_done(100, dc);
    check("t1_en_cycle", 64'(first_en), 64'(c0 + 1));
    check("t1_addr0", 64'(log_at(0)), 5);
    check("t1_valid_cycle", 64'(first_valid), 64'(c0 + 3));
    check("t1_done_cycle", 64'(dc), 64'(c0 + 7));
    check("t1_done_after_last", 64'(dc), 64'(last_hs + 1));
    check("t1_drained", 64'(exp_q.size()), 0);

    // Address wrap
    @(posedge clk); #1;
    clear_logs();
    do_start(8'd254, 9'd4, 1'b1);
    wait_done(100, dc);
    check("wrap_n", 64'(addr_log.size()), 4);
    check("wrap_a0", 64'(log_at(0)), 254);
    check("wrap_a1", 64'(log_at(1)), 255);
    check("wrap_a2", 64'(log_at(2)), 0);
    check("wrap_a3", 64'(log_at(3)), 1);
    check("wrap_drained", 64'(exp_q.size()), 0);

    // Backpressure from a fixed ready pattern with a 10-cycle low run
    bp_idx  = 0;
    bp_mode = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    do_start(8'd20, 9'd8, 1'b1);
    wait_done(400, dc);
    bp_mode = 1'b0;
    check("bp_occ_over3", 64'(max_occ > 3), 0);
    check("bp_stall_unstable", 64'(stall_errs), 0);
    check("bp_reads", 64'(addr_log.size()), 8);
    check("bp_drained", 64'(exp_q.size()), 0);
    check("bp_done_after_last", 64'(dc), 64'(last_hs + 1));

    // Zero-length burst
    @(posedge clk); #1;
    clear_logs();
    do_start(8'd7, 9'd0, 1'b1);
    wait_done(20, dc);
    check("len0_done_cycle", 64'(dc), 64'(c0 + 1));
    check("len0_busy", 64'(busy), 0);
    repeat (3) @(negedge clk);
    check("len0_no_reads", 64'(addr_log.size()), 0);
    check("len0_no_valid", 64'(first_valid), 64'(-1));

    // Start while busy is ignored
    @(posedge clk); #1;
    clear_logs();
    do_start(8'd40, 9'd6, 1'b1);
    start = 1'b1; base_addr = 8'd200; length = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, dc);
    repeat (6) @(negedge clk);
    check("busy_start_reads", 64'(addr_log.size()), 6);
    check("busy_start_last_addr", 64'(log_at(5)), 45);
    check("busy_start_drained", 64'(exp_q.size()), 0);
    check("busy_start_idle", 64'(busy), 0);

    // Reset in cycle 4 of a 16-word burst
    @(posedge clk); #1;
    clear_logs();
    dcnt = done_cnt;
    do_start(8'd60, 9'd16, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_ram_en", 64'(ram_en), 0);
    check("mid_rst_ram_addr", 64'(ram_addr), 0);
    check("mid_rst_tvalid", 64'(axis.m_tvalid), 0);
    check("mid_rst_tdata", 64'(axis.m_tdata), 0);
    check("mid_rst_tlast", 64'(axis.m_tlast), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_done", 64'(done), 0);
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", 64'(done_cnt), 64'(dcnt));
    @(posedge clk); #1;
    clear_logs();
    do_start(8'd100, 9'd3, 1'b1);
    wait_done(100, dc);
    check("post_rst_addr0", 64'(log_at(0)), 100);
    check("post_rst_valid_cycle", 64'(first_valid), 64'(c0 + 3));
    check("post_rst_drained", 64'(exp_q.size()), 0);

    // Full-depth burst reads every word once
    @(posedge clk); #1;
    clear_logs();
    do_start(8'd10, 9'd256, 1'b1);
    wait_done(800, dc);
    check("full_reads", 64'(addr_log.size()), 256);
    check("full_wrap_addr", 64'(log_at(246)), 0);
    check("full_last_addr", 64'(log_at(255)), 9);
    check("full_drained", 64'(exp_q.size()), 0);
    check("full_done_after_last", 64'(dc), 64'(last_hs + 1));

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
